mac_rx_read_ctrl: RTL and testbench
===================================

# mac_rx_read_ctrl

Receive-side sequencer between the tri-mode MAC client RX port and the on-chip frame buffer feeding the AXI read side. It requests frames from the MAC only when the buffer can hold a maximum-size frame, and writes each frame's 32-bit words into a circular word buffer. It posts one descriptor per good frame (start address, byte length) and discards oversize or malformed frames by rolling the write pointer back.

## Interface
- AW, 12, buffer word-address width; buffer depth 2^AW words
- MAX_WORDS, 512, largest accepted frame in 32-bit words; must be < 2^AW
- LEN_W, 16, byte-length field width
---
- mac_clk_i  in  1  single clock; all logic on rising edge
- mac_rst_i  in  1  asynchronous, active-high reset
- mac_rxd_i  in  32  MAC RX data word
- mac_ben_i  in  2  valid bytes on EOP word: 00=4, 01=1, 10=2, 11=3; ignored on non-EOP words
- mac_rxda_i  in  1  MAC has a frame available
- mac_rxsop_i  in  1  first word of frame (qualified by mac_rxdv_i)
- mac_rxeop_i  in  1  last word of frame (qualified by mac_rxdv_i)
- mac_rxdv_i  in  1  word valid this cycle
- mac_rxrqrd_o  out  1  read request to MAC
- buf_we_o  out  1  buffer write strobe
- buf_waddr_o  out  AW  buffer write address
- buf_wdata_o  out  32  buffer write data
- rd_ptr_i  in  AW+1  consumer's free-running read pointer (words, wraps mod 2^(AW+1))
- desc_valid_o  out  1  descriptor valid
- desc_ready_i  in  1  descriptor accepted
- desc_addr_o  out  AW  frame start word address
- desc_len_o  out  LEN_W  frame length in bytes
- wr_ptr_o  out  AW+1  committed write pointer (end of last posted frame)
- drop_cnt_o  out  16  dropped-frame count, saturating at 0xFFFF

## Operation
- Pointers: commit pointer C (= wr_ptr_o) and working pointer W, both AW+1 bits. free = 2^AW − ((C − rd_ptr_i) mod 2^(AW+1)).
- States: IDLE, REQ, DATA, DROP, DESC.
- IDLE: if mac_rxda_i=1 and free ≥ MAX_WORDS → REQ, W←C. Otherwise stay in IDLE with mac_rxrqrd_o=0; this is the backpressure mechanism.
- REQ: mac_rxrqrd_o=1. Words with dv=1 and sop=0 are ignored. A word with dv=1 and sop=1 is written at W; W++, word count N←1, then → DATA. If sop and eop arrive together, go to DESC directly.
- DATA: mac_rxrqrd_o=1. Each word with dv=1 is written at W; W++, N++.
  - eop=1 → DESC.
  - sop=1 while in DATA means a missing EOP. Drop the partial frame (W←C, drop_cnt++), then treat the word as a new SOP.
  - N would exceed MAX_WORDS → DROP, W←C, drop_cnt++, no write.
- DROP: mac_rxrqrd_o=1. Discard words until dv & eop, then → IDLE.
- DESC: mac_rxrqrd_o=0. desc_valid_o=1 with desc_addr_o=C[AW-1:0] and desc_len_o=4·(N−1)+bytes(ben of EOP word). Values are held stable until desc_ready_i=1. On acceptance C←W and → IDLE.
- Addresses wrap mod 2^AW with no special case. The free check guarantees a frame never overwrites unread data.
- drop_cnt_o saturates and never wraps.
- Reset, including mid-frame: all state cleared, and any partially written frame is forgotten because C=0 and W=0.

## Timing
- Reset values: mac_rxrqrd_o=0, buf_we_o=0, buf_waddr_o=0, buf_wdata_o=0, desc_valid_o=0, desc_addr_o=0, desc_len_o=0, wr_ptr_o=0, drop_cnt_o=0. State resets to IDLE.
- mac_rxrqrd_o is registered. It rises 1 cycle after the IDLE→REQ decision (the cycle mac_rxda_i=1 with space is sampled) and falls the cycle after EOP is accepted.
- Buffer write is registered: a word sampled with dv=1 at edge k appears as buf_we_o/addr/data after edge k, for exactly 1 cycle.
- desc_valid_o asserts the cycle after the EOP word's write strobe. Minimum 1 cycle is spent in DESC; a transfer occurs on any edge with valid & ready.
- IDLE re-evaluates space on the cycle after descriptor acceptance, so the minimum inter-frame gap is 2 cycles.
- rd_ptr_i is sampled each cycle and is assumed synchronous to mac_clk_i.

## Test plan
- Single frame, 5 words, ben=10 on EOP, rd_ptr_i=0 → words written at addresses 0..4, desc addr=0 len=18, wr_ptr_o=5 after ready.
- Desc backpressure: desc_ready_i held 0 for 10 cycles → desc_valid_o and fields stable, mac_rxrqrd_o=0 throughout, C advances only on the ready cycle.
- Wrap and full: AW=4, MAX_WORDS=8, rd_ptr_i=0, C=10 → free=6, mac_rxrqrd_o stays 0. Raise rd_ptr_i to 4 → free=10, so request. A 4-word frame writes addresses 10..13, and wr_ptr_o=14.
- Oversize: MAX_WORDS=8, frame of 9 words → 8 writes, then DROP, drop_cnt_o=1, no descriptor, wr_ptr_o unchanged. The next 2-word frame is written starting at the old C.
- Missing EOP: SOP, 3 words, then SOP with a 2-word frame → drop_cnt_o=1, one descriptor with len=8 at the original start address.
- Async reset asserted mid-DATA → all outputs 0 within the same cycle. After release, a fresh frame is written at address 0.

Source files
------------

// File: rtl/mac_rx_read_ctrl.sv
// MAC RX sequencer: requests frames only when a max-size frame fits, writes words
// into a circular buffer, posts a descriptor per good frame, rolls back bad ones.
module mac_rx_read_ctrl #(
  parameter int AW        = 12,
  parameter int MAX_WORDS = 512,
  parameter int LEN_W     = 16
) (
  input  logic              mac_clk_i,
  input  logic              mac_rst_i,
  input  logic [31:0]       mac_rxd_i,
  input  logic [1:0]        mac_ben_i,
  input  logic              mac_rxda_i,
  input  logic              mac_rxsop_i,
  input  logic              mac_rxeop_i,
  input  logic              mac_rxdv_i,
  output logic              mac_rxrqrd_o,
  output logic              buf_we_o,
  output logic [AW-1:0]     buf_waddr_o,
  output logic [31:0]       buf_wdata_o,
  input  logic [AW:0]       rd_ptr_i,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [AW-1:0]     desc_addr_o,
  output logic [LEN_W-1:0]  desc_len_o,
  output logic [AW:0]       wr_ptr_o,
  output logic [15:0]       drop_cnt_o
);

  typedef enum logic [2:0] {IDLE, REQ, DATA, DROP, DESC} state_t;

  localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;
  localparam logic [AW:0] MAX_W = (AW+1)'(MAX_WORDS);

  state_t            state_reg, state_next;
  logic [AW:0]       c_reg, c_next;
  logic [AW:0]       w_reg, w_next;
  logic [AW:0]       n_reg, n_next;
  logic [15:0]       drop_reg, drop_next;
  logic              rqrd_reg, rqrd_next;
  logic              we_reg, we_next;
  logic [AW-1:0]     waddr_reg, waddr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              desc_valid_reg, desc_valid_next;
  logic [LEN_W-1:0]  desc_len_reg, desc_len_next;

  logic [AW:0]       used;
  logic [AW:0]       free;
  logic              has_space;
  logic [2:0]        eop_bytes;
  logic              drop_inc;

  // Occupancy is measured against the committed pointer, so an in-flight frame
  // never counts as consumable space.
  assign used      = c_reg - rd_ptr_i;
  assign free      = DEPTH - used;
  assign has_space = (free >= MAX_W);
  assign eop_bytes = (mac_ben_i == 2'b00) ? 3'd4 : {1'b0, mac_ben_i};

  always_comb begin
    state_next      = state_reg;
    c_next          = c_reg;
    w_next          = w_reg;
    n_next          = n_reg;
    we_next         = 1'b0;
    waddr_next      = waddr_reg;
    wdata_next      = wdata_reg;
    desc_valid_next = 1'b0;
    desc_len_next   = desc_len_reg;
    drop_inc        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (mac_rxda_i && has_space) begin
          state_next = REQ;
          w_next     = c_reg;
        end
      end
      REQ: begin
        if (mac_rxdv_i && mac_rxsop_i) begin
          we_next    = 1'b1;
          waddr_next = w_reg[AW-1:0];
          wdata_next = mac_rxd_i;
          w_next     = w_reg + 1'b1;
          n_next     = (AW+1)'(1);
          if (mac_rxeop_i) begin
            state_next    = DESC;
            desc_len_next = LEN_W'(eop_bytes);
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (mac_rxdv_i) begin
          if (mac_rxsop_i) begin
            // Missing EOP: forget the partial frame and restart at the commit point.
            drop_inc   = 1'b1;
            we_next    = 1'b1;
            waddr_next = c_reg[AW-1:0];
            wdata_next = mac_rxd_i;
            w_next     = c_reg + 1'b1;
            n_next     = (AW+1)'(1);
            if (mac_rxeop_i) begin
              state_next    = DESC;
              desc_len_next = LEN_W'(eop_bytes);
            end
          end else if (n_reg >= MAX_W) begin
            drop_inc   = 1'b1;
            w_next     = c_reg;
            state_next = mac_rxeop_i ? IDLE : DROP;
          end else begin
            we_next    = 1'b1;
            waddr_next = w_reg[AW-1:0];
            wdata_next = mac_rxd_i;
            w_next     = w_reg + 1'b1;
            n_next     = n_reg + 1'b1;
            if (mac_rxeop_i) begin
              state_next    = DESC;
              desc_len_next = (LEN_W'(n_reg) << 2) + LEN_W'(eop_bytes);
            end
          end
        end
      end
      DROP: begin
        if (mac_rxdv_i && mac_rxeop_i) begin
          state_next = IDLE;
        end
      end
      DESC: begin
        desc_valid_next = 1'b1;
        if (desc_valid_reg && desc_ready_i) begin
          c_next          = w_reg;
          state_next      = IDLE;
          desc_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    drop_next = (drop_inc && drop_reg != 16'hFFFF) ? drop_reg + 16'd1 : drop_reg;
    rqrd_next = (state_next == REQ) || (state_next == DATA) || (state_next == DROP);
  end

  always_ff @(posedge mac_clk_i or posedge mac_rst_i) begin
    if (mac_rst_i) begin
      state_reg      <= IDLE;
      c_reg          <= '0;
      w_reg          <= '0;
      n_reg          <= '0;
      drop_reg       <= '0;
      rqrd_reg       <= 1'b0;
      we_reg         <= 1'b0;
      waddr_reg      <= '0;
      wdata_reg      <= '0;
      desc_valid_reg <= 1'b0;
      desc_len_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      c_reg          <= c_next;
      w_reg          <= w_next;
      n_reg          <= n_next;
      drop_reg       <= drop_next;
      rqrd_reg       <= rqrd_next;
      we_reg         <= we_next;
      waddr_reg      <= waddr_next;
      wdata_reg      <= wdata_next;
      desc_valid_reg <= desc_valid_next;
      desc_len_reg   <= desc_len_next;
    end
  end

  assign mac_rxrqrd_o = rqrd_reg;
  assign buf_we_o     = we_reg;
  assign buf_waddr_o  = waddr_reg;
  assign buf_wdata_o  = wdata_reg;
  assign desc_valid_o = desc_valid_reg;
  assign desc_addr_o  = c_reg[AW-1:0];
  assign desc_len_o   = desc_len_reg;
  assign wr_ptr_o     = c_reg;
  assign drop_cnt_o   = drop_reg;

endmodule

// File: tb/tb_mac_rx_read_ctrl.sv
// Directed bench for mac_rx_read_ctrl with a small buffer (AW=4, MAX_WORDS=8)
// so wrap, full and oversize cases are reachable in a few frames.
module tb_mac_rx_read_ctrl;

  localparam int AW   = 4;
  localparam int MAXW = 8;
  localparam int LW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   rxd = '0;
  logic [1:0]    ben = '0;
  logic          rxda = 1'b0;
  logic          sop = 1'b0;
  logic          eop = 1'b0;
  logic          dv = 1'b0;
  logic          rqrd;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [31:0]   buf_wdata;
  logic [AW:0]   rd_ptr = '0;
  logic          desc_valid;
  logic          desc_ready = 1'b0;
  logic [AW-1:0] desc_addr;
  logic [LW-1:0] desc_len;
  logic [AW:0]   wr_ptr;
  logic [15:0]   drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  always #5 clk = ~clk;

  mac_rx_read_ctrl #(.AW(AW), .MAX_WORDS(MAXW), .LEN_W(LW)) dut (
    .mac_clk_i    (clk),
    .mac_rst_i    (rst),
    .mac_rxd_i    (rxd),
    .mac_ben_i    (ben),
    .mac_rxda_i   (rxda),
    .mac_rxsop_i  (sop),
    .mac_rxeop_i  (eop),
    .mac_rxdv_i   (dv),
    .mac_rxrqrd_o (rqrd),
    .buf_we_o     (buf_we),
    .buf_waddr_o  (buf_waddr),
    .buf_wdata_o  (buf_wdata),
    .rd_ptr_i     (rd_ptr),
    .desc_valid_o (desc_valid),
    .desc_ready_i (desc_ready),
    .desc_addr_o  (desc_addr),
    .desc_len_o   (desc_len),
    .wr_ptr_o     (wr_ptr),
    .drop_cnt_o   (drop_cnt)
  );

  always @(negedge clk) begin
    if (!rst && buf_we) begin
      wa_q.push_back(buf_waddr);
      wd_q.push_back(buf_wdata);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rq(input string tag);
    for (int i = 0; i < 30 && !rqrd; i++) tick();
    check_val(tag, 32'(rqrd), 32'd1);
    rxda = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [31:0] base, input bit first_sop,
                            input bit last_eop, input logic [1:0] b);
    for (int i = 0; i < n; i++) begin
      rxd = base + 32'(i);
      sop = first_sop && (i == 0);
      eop = last_eop && (i == n - 1);
      ben = b;
      dv  = 1'b1;
      tick();
    end
    dv  = 1'b0;
    sop = 1'b0;
    eop = 1'b0;
    tick();
  endtask

  task automatic check_writes(input string tag, input int n, input int first, input logic [31:0] base);
    check_val({tag, "_wcnt"}, 32'(wa_q.size()), 32'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      check_val({tag, "_waddr"}, 32'(wa_q[i]), 32'((first + i) % 16));
      check_val({tag, "_wdata"}, wd_q[i], base + 32'(i));
    end
    $display("frame %s: %0d words written from addr %0d", tag, wa_q.size(), first);
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic take_desc(input string tag, input int addr, input int len, input int wp,
                           input int wp_old, input int hold);
    for (int i = 0; i < 30 && !desc_valid; i++) tick();
    check_val({tag, "_dvalid"}, 32'(desc_valid), 32'd1);
    check_val({tag, "_daddr"}, 32'(desc_addr), 32'(addr));
    check_val({tag, "_dlen"}, 32'(desc_len), 32'(len));
    for (int j = 0; j < hold; j++) begin
      tick();
      check_val({tag, "_hold_valid"}, 32'(desc_valid), 32'd1);
      check_val({tag, "_hold_len"}, 32'(desc_len), 32'(len));
      check_val({tag, "_hold_rq"}, 32'(rqrd), 32'd0);
      check_val({tag, "_hold_wptr"}, 32'(wr_ptr), 32'(wp_old));
    end
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    check_val({tag, "_wptr"}, 32'(wr_ptr), 32'(wp));
    check_val({tag, "_dvalid_off"}, 32'(desc_valid), 32'd0);
    $display("desc %s: addr=%0d len=%0d wr_ptr=%0d", tag, desc_addr, desc_len, wr_ptr);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_rq"}, 32'(rqrd), 32'd0);
    check_val({tag, "_we"}, 32'(buf_we), 32'd0);
    check_val({tag, "_waddr"}, 32'(buf_waddr), 32'd0);
    check_val({tag, "_wdata"}, buf_wdata, 32'd0);
    check_val({tag, "_dvalid"}, 32'(desc_valid), 32'd0);
    check_val({tag, "_daddr"}, 32'(desc_addr), 32'd0);
    check_val({tag, "_dlen"}, 32'(desc_len), 32'd0);
    check_val({tag, "_wptr"}, 32'(wr_ptr), 32'd0);
    check_val({tag, "_drop"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // Single 5-word frame, 2 bytes on EOP
    rxda = 1'b1;
    wait_rq("t1_rq");
    send_words(5, 32'hA000, 1, 1, 2'b10);
    check_writes("t1", 5, 0, 32'hA000);
    take_desc("t1", 0, 18, 5, 0, 0);

    // Descriptor held off for 10 cycles
    rxda = 1'b1;
    wait_rq("t2_rq");
    send_words(5, 32'hB000, 1, 1, 2'b00);
    check_writes("t2", 5, 5, 32'hB000);
    take_desc("t2", 5, 20, 10, 5, 10);

    // Only 6 free words: no request until the reader advances
    rxda = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("t3_full_rq", 32'(rqrd), 32'd0);
    end
    rd_ptr = 5'd4;
    wait_rq("t3_rq");
    send_words(4, 32'hC000, 1, 1, 2'b11);
    check_writes("t3", 4, 10, 32'hC000);
    take_desc("t3", 10, 15, 14, 10, 0);

    // Oversize 9-word frame wrapping the buffer, then a good frame at the old start
    rd_ptr = 5'd14;
    rxda = 1'b1;
    wait_rq("t4_rq");
    send_words(9, 32'hD000, 1, 1, 2'b00);
    check_writes("t4", 8, 14, 32'hD000);
    check_val("t4_drop", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t4_no_desc", 32'(desc_valid), 32'd0);
    end
    check_val("t4_rq_off", 32'(rqrd), 32'd0);
    check_val("t4_wptr", 32'(wr_ptr), 32'd14);
    rxda = 1'b1;
    wait_rq("t4b_rq");
    send_words(2, 32'hE000, 1, 1, 2'b01);
    check_writes("t4b", 2, 14, 32'hE000);
    take_desc("t4b", 14, 5, 16, 14, 0);

    // Missing EOP: 3-word partial frame then a fresh 2-word frame
    rd_ptr = 5'd16;
    rxda = 1'b1;
    wait_rq("t5_rq");
    send_words(3, 32'hF000, 1, 0, 2'b00);
    check_writes("t5a", 3, 0, 32'hF000);
    send_words(2, 32'h5000, 1, 1, 2'b00);
    check_writes("t5b", 2, 0, 32'h5000);
    check_val("t5_drop", 32'(drop_cnt), 32'd2);
    take_desc("t5", 0, 8, 18, 16, 0);

    // Asynchronous reset in the middle of a frame
    rd_ptr = 5'd18;
    rxda = 1'b1;
    wait_rq("t6_rq");
    send_words(2, 32'h6000, 1, 0, 2'b00);
    rst = 1'b1;
    #1;
    check_zero_outputs("t6_rst");
    tick();
    tick();
    rd_ptr = '0;
    rst = 1'b0;
    wa_q.delete();
    wd_q.delete();
    tick();
    rxda = 1'b1;
    wait_rq("t6b_rq");
    send_words(3, 32'h7000, 1, 1, 2'b11);
    check_writes("t6b", 3, 0, 32'h7000);
    take_desc("t6b", 0, 11, 3, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
